dcfifo_dff_pipe: RTL and testbench
==================================

# dcfifo_dff_pipe

Parameterised register pipeline that delays a multi-bit word by a fixed number of clock cycles. It is used inside the dual-clock FIFO to register and re-time read/write pointers before they are compared across clock domains, for example wrptr into the wrclk domain and then into rdclk. It is a pure data-path delay line with a synchronous clear and no handshake.

## Interface
- `lpm_delay`, default 1: number of register stages, 0 or more. A value of 0 means combinational pass-through.
- `lpm_width`, default 64: data width in bits, 1 or more.
- `clock` input, 1 bit: sole clock; all state updates on its rising edge.
- `aclr` input, 1 bit: reset, synchronous, active-high. The codebase port name is kept.
- `d` input, `lpm_width` bits: word to be delayed.
- `q` output, `lpm_width` bits: `d` delayed by `lpm_delay` cycles.

## Operation
- Internal state is an array of `lpm_delay` registers, stage[0] to stage[lpm_delay-1], each `lpm_width` bits wide.
- On each rising `clock` edge with `aclr`=0:
  - stage[0] <= d.
  - stage[k] <= stage[k-1] for k = 1 to lpm_delay-1.
- On each rising `clock` edge with `aclr`=1:
  - Every stage <= 0.
  - `d` is ignored on that edge.
- `q` = stage[lpm_delay-1]. There is no logic after the last stage.
- `lpm_delay` = 0:
  - `q` = `d` combinationally.
  - There is no storage, and `aclr` has no effect.
- Power-up/initial value of all stages is 0, so `q` reads 0 before the first clock edge.
- No arithmetic is performed. Data bits are carried verbatim, with no sign or width conversion.
- Reset and data movement are mutually exclusive within an edge. Reset wins.

## Timing
- Latency: exactly `lpm_delay` rising edges from `d` sampled to `q` valid. Throughput is one word per cycle.
- Reset value of `q`: 0, for `lpm_delay` of 1 or more, visible immediately after the first rising edge with `aclr`=1.
- Reset held N cycles: `q` stays 0 during those cycles.
- After `aclr` falls, the first `d` sampled appears on `q` `lpm_delay` edges later. Until then, `q` shows 0s as the cleared stages drain.
- Reset mid-stream: all in-flight words are discarded, and no partially shifted data survives.
- `aclr` is sampled only at clock edges. A pulse between edges has no effect.
- Parameter violations (`lpm_width` < 1 or `lpm_delay` < 0) must fail at elaboration with an error message.

## Structure
- Single module `dcfifo_dff_pipe`, no sub-modules.
- Implemented as a generate:
  - `lpm_delay` = 0 gives a wire assignment.
  - `lpm_delay` ≥ 1 gives a register array with a shift loop.
- Shared FIFO package (`dcfifo_pkg`) holds:
  - the pointer-synchroniser default `DCFIFO_PTR_SYNC_DELAY` = 1;
  - the device-family feature predicates used by the FIFO (base-Stratix, base-Cyclone, StratixII, CycloneII, StratixIII, CycloneIII, valid-family) as functions of the family-name string.
- The pipe itself depends on none of the package's family predicates.

## Test plan
- Delay 1, width 4:
  - Stimulus: reset 1 cycle, then drive `d` = 3, 5, A, F on consecutive edges.
  - Required: `q` = 0 after reset, then 3, 5, A, F, each one edge after it was sampled.
- Delay 3, width 8:
  - Stimulus: `d` = 0x11, 0x22, 0x33, 0x44.
  - Required: `q` = 0x00, 0x00 after the first two edges, then 0x11 on the third edge and 0x22 on the fourth.
- Reset mid-operation, delay 3:
  - Stimulus: load 0xAA, 0xBB, 0xCC; assert `aclr` for one edge while `d` = 0xDD; release and drive 0xEE.
  - Required:
    - `q` = 0 after the reset edge and on the next two edges; 0xDD never appears.
    - 0xEE appears on the third edge after release.
- Delay 0, width 16:
  - Stimulus: change `d` 0x1234 → 0xBEEF with no clock, then assert `aclr`.
  - Required: `q` tracks `d` immediately and stays 0xBEEF while `aclr`=1.
- Reset between edges, delay 1:
  - Stimulus: pulse `aclr` high and low between two rising edges while `q` = 0x7.
  - Required: `q` unchanged at 0x7.
- Width 1, delay 2:
  - Stimulus: toggle `d` 1, 0, 1 each cycle.
  - Required: `q` = 0, 0, 1, 0, 1 over the first five edges.

Source files
------------

// File: rtl/dcfifo_pkg.sv
// Shared dual-clock FIFO definitions: pointer-sync default and device-family
// feature predicates evaluated on the family-name string at elaboration.
package dcfifo_pkg;

  localparam int unsigned DCFIFO_PTR_SYNC_DELAY = 1;

  function automatic bit is_base_stratix(input string family);
    string f;
    f = family.toupper();
    return (f == "STRATIX") || (f == "STRATIX GX");
  endfunction

  function automatic bit is_base_cyclone(input string family);
    string f;
    f = family.toupper();
    return (f == "CYCLONE");
  endfunction

  function automatic bit is_stratixii(input string family);
    string f;
    f = family.toupper();
    return (f == "STRATIX II") || (f == "STRATIX II GX") || (f == "HARDCOPY II");
  endfunction

  function automatic bit is_cycloneii(input string family);
    string f;
    f = family.toupper();
    return (f == "CYCLONE II");
  endfunction

  function automatic bit is_stratixiii(input string family);
    string f;
    f = family.toupper();
    return (f == "STRATIX III") || (f == "STRATIX IV") || (f == "HARDCOPY III");
  endfunction

  function automatic bit is_cycloneiii(input string family);
    string f;
    f = family.toupper();
    return (f == "CYCLONE III") || (f == "CYCLONE IV E");
  endfunction

  function automatic bit is_valid_family(input string family);
    return is_base_stratix(family) || is_base_cyclone(family) ||
           is_stratixii(family)     || is_cycloneii(family)    ||
           is_stratixiii(family)    || is_cycloneiii(family);
  endfunction

endpackage

// File: rtl/dcfifo_dff_pipe.sv
// Fixed-latency register delay line used to re-time FIFO pointers; a
// synchronous clear discards every in-flight word.
module dcfifo_dff_pipe
  import dcfifo_pkg::*;
#(
  parameter int lpm_delay = int'(DCFIFO_PTR_SYNC_DELAY),
  parameter int lpm_width = 64
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic [lpm_width-1:0] d,
  output logic [lpm_width-1:0] q
);

  if (lpm_width < 1) begin : g_bad_width
    $error("dcfifo_dff_pipe: lpm_width must be 1 or more (got %0d)", lpm_width);
  end

  if (lpm_delay < 0) begin : g_bad_delay
    $error("dcfifo_dff_pipe: lpm_delay must be 0 or more (got %0d)", lpm_delay);
  end else if (lpm_delay == 0) begin : g_wire
    // Zero delay: no storage, so clock and clear are intentionally unused.
    logic unused_ctrl;
    assign unused_ctrl = clock ^ aclr;
    assign q = d;
  end else begin : g_pipe
    logic [lpm_width-1:0] stage [lpm_delay];

    always_ff @(posedge clock) begin
      if (aclr) begin
        for (int k = 0; k < lpm_delay; k++) stage[k] <= '0;
      end else begin
        stage[0] <= d;
        for (int k = 1; k < lpm_delay; k++) stage[k] <= stage[k-1];
      end
    end

    assign q = stage[lpm_delay-1];
  end

endmodule

// File: tb/tb_dcfifo_dff_pipe.sv
// Bench for dcfifo_dff_pipe: directed cases plus random traffic on four
// configurations, checked against an edge-history model.
module tb_dcfifo_dff_pipe;

  localparam int MAXE = 1024;
  localparam int NI   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: delay 1 width 4; 1: delay 3 width 8; 2: delay 0 width 16; 3: delay 2 width 1
  logic        aclr_a, aclr_b, aclr_c, aclr_e;
  logic [3:0]  d_a, q_a;
  logic [7:0]  d_b, q_b;
  logic [15:0] d_c, q_c;
  logic [0:0]  d_e, q_e;

  dcfifo_dff_pipe #(.lpm_delay(1), .lpm_width(4))  u_a (.clock(clk), .aclr(aclr_a), .d(d_a), .q(q_a));
  dcfifo_dff_pipe #(.lpm_delay(3), .lpm_width(8))  u_b (.clock(clk), .aclr(aclr_b), .d(d_b), .q(q_b));
  dcfifo_dff_pipe #(.lpm_delay(0), .lpm_width(16)) u_c (.clock(clk), .aclr(aclr_c), .d(d_c), .q(q_c));
  dcfifo_dff_pipe #(.lpm_delay(2), .lpm_width(1))  u_e (.clock(clk), .aclr(aclr_e), .d(d_e), .q(q_e));

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int          dly [NI] = '{1, 3, 0, 2};
  logic [63:0] hd  [NI][MAXE];
  bit          hr  [NI][MAXE];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  // q after edge e is the word sampled lpm_delay-1 edges earlier, unless any
  // edge in that window was a clear (or the window reaches before time zero).
  function automatic logic [63:0] model(input int i, input int e);
    int src;
    src = e - dly[i] + 1;
    if (src < 1) return 64'h0;
    for (int k = src; k <= e; k++) if (hr[i][k]) return 64'h0;
    return hd[i][src];
  endfunction

  // Record what every pipe sampled on this edge, then check all outputs.
  always @(posedge clk) begin
    n = n + 1;
    if (n < MAXE) begin
      hd[0][n] = 64'(d_a); hr[0][n] = aclr_a;
      hd[1][n] = 64'(d_b); hr[1][n] = aclr_b;
      hd[2][n] = 64'(d_c); hr[2][n] = aclr_c;
      hd[3][n] = 64'(d_e); hr[3][n] = aclr_e;
      #1;
      chk("model_d1w4",  64'(q_a), model(0, n));
      chk("model_d3w8",  64'(q_b), model(1, n));
      chk("model_d0w16", 64'(q_c), 64'(d_c));
      chk("model_d2w1",  64'(q_e), model(3, n));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    aclr_a = 1'b1; aclr_b = 1'b1; aclr_c = 1'b0; aclr_e = 1'b1;
    d_a = 4'h0; d_b = 8'h00; d_c = 16'h0000; d_e = 1'b0;

    // Delay 1 width 4: reset then 3,5,A,F
    step();
    chk("d1_reset", 64'(q_a), 64'h0);
    chk("d2_reset", 64'(q_e), 64'h0);
    aclr_a = 1'b0; d_a = 4'h3; step(); chk("d1_q3", 64'(q_a), 64'h3);
    d_a = 4'h5; step(); chk("d1_q5", 64'(q_a), 64'h5);
    d_a = 4'hA; step(); chk("d1_qA", 64'(q_a), 64'hA);
    d_a = 4'hF; step(); chk("d1_qF", 64'(q_a), 64'hF);

    // Delay 3 width 8
    aclr_b = 1'b0;
    d_b = 8'h11; step(); chk("d3_e1", 64'(q_b), 64'h00);
    d_b = 8'h22; step(); chk("d3_e2", 64'(q_b), 64'h00);
    d_b = 8'h33; step(); chk("d3_e3", 64'(q_b), 64'h11);
    d_b = 8'h44; step(); chk("d3_e4", 64'(q_b), 64'h22);

    // Mid-stream clear on delay 3
    d_b = 8'hAA; step();
    d_b = 8'hBB; step();
    d_b = 8'hCC; step();
    aclr_b = 1'b1; d_b = 8'hDD; step(); chk("mid_rst_edge", 64'(q_b), 64'h00);
    aclr_b = 1'b0; d_b = 8'hEE; step(); chk("mid_rel1", 64'(q_b), 64'h00);
    d_b = 8'h00; step(); chk("mid_rel2", 64'(q_b), 64'h00);
    step(); chk("mid_rel3", 64'(q_b), 64'hEE);

    // Delay 0: combinational, clear ignored
    d_c = 16'h1234; #1; chk("d0_1234", 64'(q_c), 64'h1234);
    d_c = 16'hBEEF; #1; chk("d0_beef", 64'(q_c), 64'hBEEF);
    aclr_c = 1'b1; step(); chk("d0_aclr", 64'(q_c), 64'hBEEF);
    aclr_c = 1'b0;

    // Clear pulse between edges has no effect
    d_a = 4'h7; step(); chk("pulse_pre", 64'(q_a), 64'h7);
    aclr_a = 1'b1; #2; aclr_a = 1'b0; #1;
    chk("pulse_mid", 64'(q_a), 64'h7);
    step(); chk("pulse_post", 64'(q_a), 64'h7);

    // Width 1 delay 2: reset edge, then 1,0,1
    aclr_e = 1'b1; step(); chk("w1_e1", 64'(q_e), 64'h0);
    aclr_e = 1'b0; d_e = 1'b1; step(); chk("w1_e2", 64'(q_e), 64'h0);
    d_e = 1'b0; step(); chk("w1_e3", 64'(q_e), 64'h1);
    d_e = 1'b1; step(); chk("w1_e4", 64'(q_e), 64'h0);
    d_e = 1'b0; step(); chk("w1_e5", 64'(q_e), 64'h1);

    // Random traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      d_a = 4'($urandom);  aclr_a = ($urandom_range(0, 9) == 0);
      d_b = 8'($urandom);  aclr_b = ($urandom_range(0, 9) == 0);
      d_c = 16'($urandom); aclr_c = ($urandom_range(0, 9) == 0);
      d_e = 1'($urandom);  aclr_e = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
